regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and scoreboard in front of the CPU's 16 x 32-bit register file, which has a single write port.
- Shares that write port between two requesters: the ALU write-back and the load/store (MEM) write-back, using round-robin priority.
- Keeps a per-register busy mask of issued-but-not-yet-written destinations.
- Raises a stall to the decode stage when a source register is still busy.

Parameters:
- NREGS, 16, number of architectural registers; busy mask width.
- RW, 4, register index width; must equal clog2(NREGS).
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU write-back request.
- alu_reg  input  RW  ALU destination register.
- alu_data  input  DW  ALU result.
- alu_ready  output  1  ALU request granted this cycle (combinational).
- mem_valid  input  1  MEM write-back request.
- mem_reg  input  RW  MEM destination register.
- mem_data  input  DW  MEM load data.
- mem_ready  output  1  MEM request granted this cycle (combinational).
- issue_en  input  1  decode issued an instruction with a destination.
- issue_reg  input  RW  destination of the issued instruction.
- chk_enA  input  1  source A is used.
- chk_regA  input  RW  source A index.
- chk_enB  input  1  source B is used.
- chk_regB  input  RW  source B index.
- stall  output  1  a used source is busy (combinational from busy state).
- rf_write_en  output  1  register-file write enable (registered).
- rf_write_reg  output  RW  register-file write index (registered).
- rf_write_data  output  DW  register-file write data (registered).
- busy_mask  output  NREGS  current scoreboard state.
- err  output  1  sticky protocol error flag.

Behaviour:
- Reset (reset low, asynchronous):
  - rf_write_en=0, rf_write_reg=0, rf_write_data=0.
  - busy_mask=0, err=0.
  - last_grant=MEM, so the ALU wins the first contention.
  - Any grant captured but not yet written is discarded.
- Arbitration (combinational, same cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant, and last_grant holds.
  - At most one ready is high in any cycle.
  - last_grant updates on every grant.
  - A waiting requester is granted within 1 cycle of losing.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - A requester holds valid, reg and data stable until ready is seen.
  - ready never depends on the requester's own data.
- Write stage, one-cycle latency:
  - A transfer in cycle N produces rf_write_en=1 in cycle N+1, with the captured reg and data.
  - With no transfer, rf_write_en=0 next cycle; rf_write_reg and rf_write_data hold their last values.
  - Back-to-back transfers give back-to-back writes.
- Scoreboard:
  - issue_en sets busy[issue_reg] on the clock edge.
  - A committed write (rf_write_en=1) clears busy[rf_write_reg] on the same edge.
  - Set and clear of the same register on the same edge: set wins, so the register stays busy.
  - Set and clear of different registers on the same edge: both take effect.
- stall = (chk_enA & busy[chk_regA]) | (chk_enB & busy[chk_regB]).
  - stall uses the registered busy state only; issue_en in the same cycle does not affect it.
- Error conditions (err sets and stays set until reset):
  - issue_en to a register that is already busy; the register remains busy.
  - A transfer whose destination is not busy; the write is still performed.
- busy_mask is a direct view of the busy registers.

Test Plan:
- Reset, then alu_valid=1 (alu_reg=3, alu_data=0xDEADBEEF) with mem_valid=0 -> alu_ready=1 in cycle 0; cycle 1: rf_write_en=1, rf_write_reg=3, rf_write_data=0xDEADBEEF.
- After reset, both requesters held valid for 4 cycles (alu_reg=1, mem_reg=2) -> grants ALU, MEM, ALU, MEM; rf_write_reg sequence 1,2,1,2, starting one cycle later.
- issue_en with issue_reg=5, then chk_enA=1, chk_regA=5 -> stall=1 from the next cycle until the cycle after the write to r5 commits; chk_enA=0 -> stall=0.
- issue_reg=7 asserted on the same edge that commits a write to r7 -> busy_mask[7]=1 afterwards, err=0.
- issue_en to r4 twice with no write in between -> err=1 and stays 1; a MEM write to r9 with r9 not busy -> write performed, err=1.
- Assert reset low mid-cycle, one cycle after a grant -> rf_write_en=0 immediately, busy_mask=0, captured write lost; after release the ALU wins the first contention.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of write-back requests, scoreboard check/issue signals and register-file
// write outputs around the write-back arbiter.
interface regfile_wb_arbiter_if #(
   parameter int NREGS = 16,
   parameter int RW    = 4,
   parameter int DW    = 32
);
   logic             alu_valid;
   logic [RW-1:0]    alu_reg;
   logic [DW-1:0]    alu_data;
   logic             alu_ready;

   logic             mem_valid;
   logic [RW-1:0]    mem_reg;
   logic [DW-1:0]    mem_data;
   logic             mem_ready;

   logic             issue_en;
   logic [RW-1:0]    issue_reg;

   logic             chk_enA;
   logic [RW-1:0]    chk_regA;
   logic             chk_enB;
   logic [RW-1:0]    chk_regB;
   logic             stall;

   logic             rf_write_en;
   logic [RW-1:0]    rf_write_reg;
   logic [DW-1:0]    rf_write_data;
   logic [NREGS-1:0] busy_mask;
   logic             err;

   modport master (
      output alu_valid, alu_reg, alu_data,
      output mem_valid, mem_reg, mem_data,
      output issue_en, issue_reg,
      output chk_enA, chk_regA, chk_enB, chk_regB,
      input  alu_ready, mem_ready, stall,
      input  rf_write_en, rf_write_reg, rf_write_data, busy_mask, err
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data,
      input  mem_valid, mem_reg, mem_data,
      input  issue_en, issue_reg,
      input  chk_enA, chk_regA, chk_enB, chk_regB,
      output alu_ready, mem_ready, stall,
      output rf_write_en, rf_write_reg, rf_write_data, busy_mask, err
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin ALU/MEM arbiter for the single register-file write port, with a
// busy-register scoreboard that stalls decode on pending destinations.
module regfile_wb_arbiter #(
   parameter int NREGS = 16,
   parameter int RW    = 4,
   parameter int DW    = 32
) (
   input logic                clk,
   input logic                reset,
   regfile_wb_arbiter_if.slave bus
);
   logic             last_mem_reg;
   logic             wen_reg;
   logic [RW-1:0]    wreg_reg;
   logic [DW-1:0]    wdata_reg;
   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;
   logic             err_reg;
   logic             err_next;

   logic             alu_grant;
   logic             mem_grant;
   logic             xfer;
   logic [RW-1:0]    xfer_dst;
   logic [DW-1:0]    xfer_data;
   logic             commit_hit;

   // On contention the requester that did not win last time gets the port.
   assign alu_grant = bus.alu_valid & (~bus.mem_valid | last_mem_reg);
   assign mem_grant = bus.mem_valid & (~bus.alu_valid | ~last_mem_reg);
   assign xfer      = alu_grant | mem_grant;
   assign xfer_dst  = alu_grant ? bus.alu_reg  : bus.mem_reg;
   assign xfer_data = alu_grant ? bus.alu_data : bus.mem_data;

   // A register freed by this edge's commit may be re-issued without error.
   assign commit_hit = wen_reg & (wreg_reg == bus.issue_reg);
   assign err_next   = err_reg
                     | (bus.issue_en & busy_reg[bus.issue_reg] & ~commit_hit)
                     | (xfer & ~busy_reg[xfer_dst]);

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_busy
         logic set_hit;
         logic clr_hit;
         assign set_hit = bus.issue_en & (bus.issue_reg == RW'(gi));
         assign clr_hit = wen_reg & (wreg_reg == RW'(gi));
         // Set dominates so a same-edge re-issue keeps the register busy.
         assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_mem_reg <= 1'b1;
         wen_reg      <= 1'b0;
         wreg_reg     <= '0;
         wdata_reg    <= '0;
         busy_reg     <= '0;
         err_reg      <= 1'b0;
      end else begin
         if (xfer) begin
            last_mem_reg <= mem_grant;
            wreg_reg     <= xfer_dst;
            wdata_reg    <= xfer_data;
         end
         wen_reg  <= xfer;
         busy_reg <= busy_next;
         err_reg  <= err_next;
      end
   end

   assign bus.alu_ready     = alu_grant;
   assign bus.mem_ready     = mem_grant;
   assign bus.stall         = (bus.chk_enA & busy_reg[bus.chk_regA])
                            | (bus.chk_enB & busy_reg[bus.chk_regB]);
   assign bus.rf_write_en   = wen_reg;
   assign bus.rf_write_reg  = wreg_reg;
   assign bus.rf_write_data = wdata_reg;
   assign bus.busy_mask     = busy_reg;
   assign bus.err           = err_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural
// model of grant order, pending writes, busy set and sticky error.
module tb_regfile_wb_arbiter;
   localparam int NREGS = 16;
   localparam int RW    = 4;
   localparam int DW    = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NREGS(NREGS), .RW(RW), .DW(DW)) bus();

   regfile_wb_arbiter #(.NREGS(NREGS), .RW(RW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: busy set, sticky error, last winner (0 = ALU, 1 = MEM), write stage.
   bit [NREGS-1:0] m_busy;
   bit             m_err;
   int             m_prev;
   bit             m_wen;
   bit [RW-1:0]    m_wreg;
   bit [DW-1:0]    m_wdata;
   bit             g_alu;
   bit             g_mem;

   task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
      bus.issue_en  = 1'b0; bus.issue_reg = '0;
      bus.chk_enA   = 1'b0; bus.chk_regA = '0;
      bus.chk_enB   = 1'b0; bus.chk_regB = '0;
   endtask

   task automatic model_reset();
      m_busy = '0; m_err = 1'b0; m_prev = 1;
      m_wen = 1'b0; m_wreg = '0; m_wdata = '0;
   endtask

   task automatic check_state(string tag);
      check_eq({tag, ".wen"},   bus.rf_write_en,   m_wen);
      check_eq({tag, ".wreg"},  bus.rf_write_reg,  m_wreg);
      check_eq({tag, ".wdata"}, bus.rf_write_data, m_wdata);
      check_eq({tag, ".busy"},  bus.busy_mask,     m_busy);
      check_eq({tag, ".err"},   bus.err,           m_err);
   endtask

   // Inputs are already driven (posedge+1); check at negedge, advance model, return at posedge+1.
   task automatic cycle(string tag);
      bit          xfer;
      bit          exp_stall;
      bit [RW-1:0] dst;
      bit [DW-1:0] dat;
      @(negedge clk);
      g_alu = bus.alu_valid && (!bus.mem_valid || m_prev == 1);
      g_mem = bus.mem_valid && (!bus.alu_valid || m_prev == 0);
      exp_stall = (bus.chk_enA && m_busy[bus.chk_regA]) || (bus.chk_enB && m_busy[bus.chk_regB]);
      check_eq({tag, ".alu_ready"}, bus.alu_ready, g_alu);
      check_eq({tag, ".mem_ready"}, bus.mem_ready, g_mem);
      check_eq({tag, ".stall"},     bus.stall,     exp_stall);
      check_state(tag);

      xfer = g_alu || g_mem;
      dst  = g_alu ? bus.alu_reg  : bus.mem_reg;
      dat  = g_alu ? bus.alu_data : bus.mem_data;
      if (bus.issue_en && m_busy[bus.issue_reg] && !(m_wen && m_wreg == bus.issue_reg)) m_err = 1'b1;
      if (xfer && !m_busy[dst]) m_err = 1'b1;
      if (m_wen) m_busy[m_wreg] = 1'b0;
      if (bus.issue_en) m_busy[bus.issue_reg] = 1'b1;
      if (xfer) begin
         m_wen = 1'b1; m_wreg = dst; m_wdata = dat;
         m_prev = g_alu ? 0 : 1;
         $display("[%0t] %s: %s -> r%0d = 0x%08h", $time, tag, g_alu ? "ALU" : "MEM", dst, dat);
      end else begin
         m_wen = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(string tag);
      idle();
      reset = 1'b0;
      #1;
      model_reset();
      check_state(tag);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   function automatic bit [RW-1:0] pick_dst();
      int tries;
      bit [RW-1:0] r;
      r = RW'($urandom_range(0, NREGS - 1));
      if (m_busy != '0 && $urandom_range(0, 9) < 9) begin
         tries = 0;
         while (!m_busy[r] && tries < 64) begin
            r = RW'($urandom_range(0, NREGS - 1));
            tries++;
         end
      end
      return r;
   endfunction

   initial begin
      bit [RW-1:0] exp_seq [4];
      bit          alu_pend;
      bit          mem_pend;
      exp_seq[0] = 4'd1; exp_seq[1] = 4'd2; exp_seq[2] = 4'd1; exp_seq[3] = 4'd2;

      // Reset, then a lone ALU request.
      do_reset("rst0");
      bus.alu_valid = 1'b1; bus.alu_reg = 4'd3; bus.alu_data = 32'hDEADBEEF;
      cycle("t1");
      idle();
      check_eq("t1.wen",   bus.rf_write_en, 1);
      check_eq("t1.wreg",  bus.rf_write_reg, 3);
      check_eq("t1.wdata", bus.rf_write_data, 32'hDEADBEEF);
      cycle("t1_idle");

      // Sustained contention alternates ALU, MEM, ALU, MEM.
      do_reset("rst1");
      bus.alu_valid = 1'b1; bus.alu_reg = 4'd1; bus.alu_data = 32'h1111_0000;
      bus.mem_valid = 1'b1; bus.mem_reg = 4'd2; bus.mem_data = 32'h2222_0000;
      for (int i = 0; i < 4; i++) begin
         cycle("t2");
         check_eq("t2.grant_alu", g_alu, (i % 2) == 0);
         check_eq("t2.wreg_seq", bus.rf_write_reg, exp_seq[i]);
      end
      idle();
      cycle("t2_idle");

      // Stall on a pending destination until its write commits.
      do_reset("rst2");
      bus.issue_en = 1'b1; bus.issue_reg = 4'd5;
      cycle("t3_issue");
      bus.issue_en = 1'b0;
      bus.chk_enA = 1'b1; bus.chk_regA = 4'd5;
      cycle("t3_wait");
      check_eq("t3.stall_hold", bus.stall, 1);
      bus.alu_valid = 1'b1; bus.alu_reg = 4'd5; bus.alu_data = 32'h5555_5555;
      cycle("t3_xfer");
      bus.alu_valid = 1'b0;
      check_eq("t3.stall_commit", bus.stall, 1);
      cycle("t3_commit");
      check_eq("t3.stall_clear", bus.stall, 0);
      bus.chk_enA = 1'b0; bus.chk_regA = 4'd0;
      cycle("t3_off");

      // Re-issue on the committing edge keeps r7 busy without an error.
      do_reset("rst3");
      bus.issue_en = 1'b1; bus.issue_reg = 4'd7;
      cycle("t4_issue");
      bus.issue_en = 1'b0;
      bus.alu_valid = 1'b1; bus.alu_reg = 4'd7; bus.alu_data = 32'h7777_0007;
      cycle("t4_xfer");
      bus.alu_valid = 1'b0;
      bus.issue_en = 1'b1; bus.issue_reg = 4'd7;
      cycle("t4_reissue");
      bus.issue_en = 1'b0;
      check_eq("t4.busy7", bus.busy_mask[7], 1);
      check_eq("t4.err", bus.err, 0);
      cycle("t4_idle");

      // Double issue sets error; a write to a non-busy register still lands.
      do_reset("rst4");
      bus.issue_en = 1'b1; bus.issue_reg = 4'd4;
      cycle("t5_issue_a");
      cycle("t5_issue_b");
      bus.issue_en = 1'b0;
      check_eq("t5.err_set", bus.err, 1);
      bus.mem_valid = 1'b1; bus.mem_reg = 4'd9; bus.mem_data = 32'h9999_AAAA;
      cycle("t5_mem9");
      bus.mem_valid = 1'b0;
      check_eq("t5.wreg9", bus.rf_write_reg, 9);
      check_eq("t5.err_sticky", bus.err, 1);
      cycle("t5_idle");

      // Asynchronous reset discards a captured write; ALU then wins contention.
      bus.issue_en = 1'b1; bus.issue_reg = 4'd6;
      bus.alu_valid = 1'b1; bus.alu_reg = 4'd6; bus.alu_data = 32'h6666_6666;
      cycle("t6_grant");
      idle();
      check_eq("t6.wen_before", bus.rf_write_en, 1);
      #1;
      reset = 1'b0;
      #1;
      model_reset();
      check_state("t6_async");
      @(posedge clk); #1;
      reset = 1'b1;
      bus.alu_valid = 1'b1; bus.alu_reg = 4'd8; bus.alu_data = 32'h8888_0001;
      bus.mem_valid = 1'b1; bus.mem_reg = 4'd9; bus.mem_data = 32'h9999_0001;
      cycle("t6_contend");
      check_eq("t6.alu_first", g_alu, 1);
      idle();
      cycle("t6_idle");

      // Randomized traffic with requesters honouring the hold-until-ready rule.
      alu_pend = 1'b0;
      mem_pend = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (c % 100 == 0) begin
            do_reset("rnd_rst");
            alu_pend = 1'b0;
            mem_pend = 1'b0;
         end
         if (!alu_pend && $urandom_range(0, 3) != 0) begin
            alu_pend = 1'b1;
            bus.alu_valid = 1'b1; bus.alu_reg = pick_dst(); bus.alu_data = $urandom;
         end
         if (!mem_pend && $urandom_range(0, 2) == 0) begin
            mem_pend = 1'b1;
            bus.mem_valid = 1'b1; bus.mem_reg = pick_dst(); bus.mem_data = $urandom;
         end
         bus.issue_en  = ($urandom_range(0, 2) == 0);
         bus.issue_reg = RW'($urandom_range(0, NREGS - 1));
         bus.chk_enA   = $urandom_range(0, 1) == 1;
         bus.chk_regA  = RW'($urandom_range(0, NREGS - 1));
         bus.chk_enB   = $urandom_range(0, 1) == 1;
         bus.chk_regB  = RW'($urandom_range(0, NREGS - 1));
         cycle("rnd");
         if (g_alu) begin alu_pend = 1'b0; bus.alu_valid = 1'b0; end
         if (g_mem) begin mem_pend = 1'b0; bus.mem_valid = 1'b0; end
      end
      idle();
      cycle("rnd_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
